dirty_flush_controller: RTL and testbench
=========================================

DIRTY_FLUSH_CONTROLLER -- requirements
Module: dirty_flush_controller

Interface
REQ-001 Parameter: NUM_LINES, 64, number of tracked cache lines; all line vectors are NUM_LINES wide, line indices are 6 bits.
REQ-002 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-003 Port: clk  input  1  rising-edge clock.
REQ-004 Port: rst_n  input  1  asynchronous active-low reset.
REQ-005 Port: flush_req  input  1  request to write back every dirty line, then clear all dirty bits.
REQ-006 Port: wr_hit  input  1  cache write hit; the addressed line becomes dirty.
REQ-007 Port: wr_line  input  6  line index for wr_hit.
REQ-008 Port: dirty_bits  input  64  current dirty-latch outputs.
REQ-009 Port: dirty_set  output  1  set strobe to the dirty-latch array.
REQ-010 Port: dirty_sel  output  64  one-hot line selector to the dirty-latch array.
REQ-011 Port: dirty_clr  output  1  clear strobe to the dirty-latch array.
REQ-012 Port: wb_req  output  1  write-back request to the memory interface.
REQ-013 Port: wb_line  output  6  line index being written back.
REQ-014 Port: wb_ack  input  1  write-back complete.
REQ-015 Port: busy  output  1  flush in progress.
REQ-016 Port: wr_stall  output  1  cache writes held off.
REQ-017 Port: done  output  1  one-cycle flush-complete pulse.

Function
REQ-018 The block SHALL implement states IDLE, SCAN, WAIT and CLEAR.
REQ-019 In IDLE: flush_req=1 SHALL capture dirty_bits into a 64-bit pending register and move to SCAN; flush_req=0 SHALL leave the block in IDLE.
REQ-020 In SCAN: pending==0 SHALL move to CLEAR; otherwise wb_line SHALL be loaded with the lowest set pending index and the block SHALL move to WAIT.
REQ-021 In WAIT: wb_req SHALL be 1 and wb_line SHALL be held stable.
REQ-022 In WAIT, wb_ack=1 at a rising edge SHALL clear pending[wb_line] and move to SCAN; wb_ack=0 SHALL stay in WAIT with no timeout.
REQ-023 In CLEAR: dirty_clr=1 and done=1 for exactly one cycle, then the block SHALL move to IDLE.
REQ-024 busy SHALL be 1 in SCAN, WAIT and CLEAR, and 0 in IDLE.
REQ-025 wr_stall SHALL equal busy.
REQ-026 dirty_set SHALL be wr_hit AND NOT busy (combinational).
REQ-027 dirty_sel SHALL be the one-hot decode of wr_line when dirty_set=1, else all zeros.
REQ-028 Writes SHALL never set a dirty bit during a flush, so dirty_clr cannot erase an unflushed write.
REQ-029 wb_ack outside WAIT SHALL be ignored.
REQ-030 flush_req while busy SHALL be ignored (not queued).
REQ-031 dirty_bits changes after capture SHALL not affect the flush in progress.
REQ-032 Timing: empty flush SHALL take 3 cycles from flush_req sample to IDLE (SCAN, CLEAR, IDLE). Each dirty line SHALL cost 1 SCAN cycle plus at least 1 WAIT cycle.
REQ-033 Lines SHALL be written back in ascending index order, each exactly once.

Reset
REQ-034 When rst_n=0, the block SHALL asynchronously enter IDLE with pending=0, wb_line=0, and all outputs 0 (wb_req, busy, wr_stall, done, dirty_clr, dirty_set, dirty_sel).
REQ-035 Reset during a flush SHALL abort it with no dirty_clr pulse; the dirty latches keep their contents.
REQ-036 Operation SHALL resume on the first rising clk edge after rst_n deasserts.

Verification
REQ-037 Empty flush: dirty_bits=0, pulse flush_req -> no wb_req; dirty_clr=1 and done=1 together for 1 cycle, 2 cycles after the flush_req sample edge; busy low afterward.
REQ-038 Ordered write-back: dirty_bits=0x8000_0000_0000_0021, ack each request immediately -> wb_line sequence 0, 5, 63; then one dirty_clr pulse.
REQ-039 Back-pressure: one dirty line 10, wb_ack delayed 7 cycles -> wb_req held 1 and wb_line=10 for all 7 cycles; a stray wb_ack in SCAN has no effect.
REQ-040 Write stall: wr_hit=1, wr_line=3 while idle -> dirty_set=1, dirty_sel=0x8; the same write during busy -> dirty_set=0, dirty_sel=0, wr_stall=1.
REQ-041 Abort: assert rst_n=0 in WAIT -> all outputs 0 immediately; no dirty_clr; a subsequent flush_req restarts the flush from the lowest dirty line.

Source files
------------

// File: rtl/dirty_flush_controller.sv
// dirty_flush_controller
//   Walks a snapshot of the dirty-line vector, issuing one write-back per
//   dirty line in ascending index order. After the last write-back it pulses
//   a clear strobe to the dirty-latch array. While a flush is in progress,
//   cache writes are stalled so that no line can become dirty after the
//   snapshot and then be wiped by the clear.
// Ports
//   clk, rst_n       clock, asynchronous active-low reset
//   flush_req        start a flush (ignored while busy)
//   wr_hit, wr_line  cache write hit and its line index
//   dirty_bits       current dirty-latch outputs
//   dirty_set        set strobe to the dirty latches (wr_hit and not busy)
//   dirty_sel        one-hot line select for dirty_set
//   dirty_clr        clear-all strobe to the dirty latches
//   wb_req, wb_line  write-back request and line index
//   wb_ack           write-back complete (only honoured in WAIT)
//   busy, wr_stall   flush in progress
//   done             one-cycle flush-complete pulse
module dirty_flush_controller #(
  parameter int NUM_LINES = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush_req,
  input  logic                 wr_hit,
  input  logic [5:0]           wr_line,
  input  logic [NUM_LINES-1:0] dirty_bits,
  output logic                 dirty_set,
  output logic [NUM_LINES-1:0] dirty_sel,
  output logic                 dirty_clr,
  output logic                 wb_req,
  output logic [5:0]           wb_line,
  input  logic                 wb_ack,
  output logic                 busy,
  output logic                 wr_stall,
  output logic                 done
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_WAIT  = 2'd2,
    ST_CLEAR = 2'd3
  } state_t;

  state_t                 state_q, state_d;
  logic [NUM_LINES-1:0]   pending_q, pending_d;
  logic [5:0]             wb_line_q, wb_line_d;
  logic                   busy_q, busy_d;
  logic                   wb_req_q, wb_req_d;
  logic                   clr_q, clr_d;

  // Index of the lowest set bit; the scan loop runs high-to-low so the
  // lowest hit is the last one written.
  function automatic logic [5:0] lowest_set(input logic [NUM_LINES-1:0] v);
    logic [5:0] idx;
    idx = 6'd0;
    for (int i = NUM_LINES - 1; i >= 0; i--) begin
      if (v[i]) begin
        idx = 6'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

  // Next-state, pending snapshot and write-back line selection.
  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    wb_line_d = wb_line_q;
    case (state_q)
      ST_IDLE: begin
        if (flush_req) begin
          pending_d = dirty_bits;
          state_d   = ST_SCAN;
        end else begin
          state_d   = ST_IDLE;
        end
      end
      ST_SCAN: begin
        if (pending_q == '0) begin
          state_d   = ST_CLEAR;
        end else begin
          wb_line_d = lowest_set(pending_q);
          state_d   = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (wb_ack) begin
          pending_d[wb_line_q] = 1'b0;
          state_d              = ST_SCAN;
        end else begin
          state_d              = ST_WAIT;
        end
      end
      ST_CLEAR: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d   = ST_IDLE;
        pending_d = '0;
        wb_line_d = 6'd0;
      end
    endcase
  end

  // Status outputs are registered from the next state so they line up
  // exactly with the state they describe.
  always_comb begin
    busy_d   = (state_d != ST_IDLE);
    wb_req_d = (state_d == ST_WAIT);
    clr_d    = (state_d == ST_CLEAR);
  end

  // State and output registers; reset aborts any flush without a clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      pending_q <= '0;
      wb_line_q <= 6'd0;
      busy_q    <= 1'b0;
      wb_req_q  <= 1'b0;
      clr_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      wb_line_q <= wb_line_d;
      busy_q    <= busy_d;
      wb_req_q  <= wb_req_d;
      clr_q     <= clr_d;
    end
  end

  // Write path: a hit may only set a dirty bit when no flush is running.
  // rst_n gating keeps the strobe low while reset is held.
  always_comb begin
    dirty_set = wr_hit & ~busy_q & rst_n;
    dirty_sel = '0;
    if (dirty_set) begin
      dirty_sel[wr_line] = 1'b1;
    end else begin
      dirty_sel = '0;
    end
  end

  assign busy      = busy_q;
  assign wr_stall  = busy_q;
  assign wb_req    = wb_req_q;
  assign wb_line   = wb_line_q;
  assign dirty_clr = clr_q;
  assign done      = clr_q;

endmodule

// File: tb/tb_dirty_flush_controller.sv
module tb_dirty_flush_controller;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush_req = 1'b0;
  logic        wr_hit = 1'b0;
  logic [5:0]  wr_line = 6'd0;
  logic [63:0] dirty_bits = 64'd0;
  logic        dirty_set;
  logic [63:0] dirty_sel;
  logic        dirty_clr;
  logic        wb_req;
  logic [5:0]  wb_line;
  logic        wb_ack = 1'b0;
  logic        busy;
  logic        wr_stall;
  logic        done;

  int n_tests = 0;
  int n_fail  = 0;
  logic [5:0] exp_q[$];

  dirty_flush_controller #(.NUM_LINES(64)) dut (
    .clk(clk), .rst_n(rst_n), .flush_req(flush_req), .wr_hit(wr_hit),
    .wr_line(wr_line), .dirty_bits(dirty_bits), .dirty_set(dirty_set),
    .dirty_sel(dirty_sel), .dirty_clr(dirty_clr), .wb_req(wb_req),
    .wb_line(wb_line), .wb_ack(wb_ack), .busy(busy), .wr_stall(wr_stall),
    .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Run one flush: expected write-back lines are pushed in ascending order,
  // then popped as each request is acknowledged after ack_dly wait cycles.
  task automatic do_flush(input logic [63:0] bits, input int ack_dly, input logic stray);
    int  waitc;
    int  reqc;
    int  clr_cnt;
    int  clr_cyc;
    int  nlines;
    bit  fin;
    logic [5:0] held;
    exp_q.delete();
    nlines = 0;
    for (int i = 0; i < 64; i++) begin
      if (bits[i]) begin
        exp_q.push_back(6'(i));
        nlines++;
      end
    end
    dirty_bits = bits;
    @(negedge clk);
    flush_req = 1'b1;
    @(negedge clk);
    flush_req = 1'b0;
    dirty_bits = ~bits;     // later latch changes must not disturb the flush
    chk("busy_start", {63'd0, busy}, 64'd1);
    waitc = 0; reqc = 0; clr_cnt = 0; clr_cyc = -1; fin = 0; held = 6'd0;
    for (int cyc = 0; cyc < 2000 && !fin; cyc++) begin
      if (wb_req) begin
        if (exp_q.size() == 0) begin
          chk("wb_extra", 64'd1, 64'd0);
        end else begin
          chk("wb_line", {58'd0, wb_line}, {58'd0, exp_q[0]});
        end
        if (waitc > 0) chk("wb_line_stable", {58'd0, wb_line}, {58'd0, held});
        held = wb_line;
        reqc++;
        if (waitc == ack_dly) begin
          wb_ack = 1'b1;
          waitc  = 0;
          chk("wb_req_cycles", 64'(reqc), 64'(ack_dly + 1));
          reqc = 0;
          if (exp_q.size() > 0) void'(exp_q.pop_front());
        end else begin
          wb_ack = 1'b0;
          waitc++;
        end
      end else begin
        wb_ack = stray;
        if (dirty_clr) begin
          chk("done_with_clr", {63'd0, done}, 64'd1);
          chk("clr_queue_empty", 64'(exp_q.size()), 64'd0);
          clr_cnt++;
          clr_cyc = cyc;
        end else if (!busy) begin
          fin = 1;
        end else begin
          chk("done_low", {63'd0, done}, 64'd0);
        end
      end
      if (busy) begin
        wr_hit  = 1'b1;
        wr_line = 6'd3;
        #1;
        chk("stall_set", {63'd0, dirty_set}, 64'd0);
        chk("stall_sel", dirty_sel, 64'd0);
        chk("stall_flag", {63'd0, wr_stall}, 64'd1);
        wr_hit = 1'b0;
      end
      @(negedge clk);
    end
    wb_ack = 1'b0;
    chk("flush_finished", {63'd0, fin}, 64'd1);
    chk("clr_pulses", 64'(clr_cnt), 64'd1);
    chk("clr_cycle", 64'(clr_cyc), 64'(nlines * (ack_dly + 2) + 1));
    chk("busy_end", {63'd0, busy}, 64'd0);
  endtask

  initial begin
    // Reset state
    #2;
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_wb_req", {63'd0, wb_req}, 64'd0);
    chk("rst_wb_line", {58'd0, wb_line}, 64'd0);
    chk("rst_clr", {62'd0, dirty_clr, done}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Idle write sets the addressed dirty bit
    wr_hit = 1'b1; wr_line = 6'd3; #1;
    chk("idle_set", {63'd0, dirty_set}, 64'd1);
    chk("idle_sel3", dirty_sel, 64'h8);
    wr_line = 6'd63; #1;
    chk("idle_sel63", dirty_sel, 64'h8000_0000_0000_0000);
    wr_hit = 1'b0; #1;
    chk("idle_nohit", dirty_sel, 64'd0);

    do_flush(64'd0, 0, 1'b0);                      // empty flush
    do_flush(64'h8000_0000_0000_0021, 0, 1'b0);    // ordered 0,5,63
    do_flush(64'h0000_0000_0000_0400, 6, 1'b1);    // line 10, ack after 7 req cycles, stray acks
    do_flush(64'h0000_00F0_0000_1002, 2, 1'b0);

    // Abort in WAIT
    dirty_bits = 64'h8000_0000_0000_0021;
    @(negedge clk); flush_req = 1'b1;
    @(negedge clk); flush_req = 1'b0;
    for (int i = 0; i < 50 && !wb_req; i++) @(negedge clk);
    chk("abort_reached_wait", {63'd0, wb_req}, 64'd1);
    wr_hit = 1'b1; wr_line = 6'd7;
    rst_n = 1'b0; #1;
    chk("abort_outs", {58'd0, wb_req, busy, wr_stall, done, dirty_clr, dirty_set}, 64'd0);
    chk("abort_sel", dirty_sel, 64'd0);
    chk("abort_line", {58'd0, wb_line}, 64'd0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("abort_no_clr", {63'd0, dirty_clr}, 64'd0);
    end
    wr_hit = 1'b0;
    rst_n = 1'b1;
    do_flush(64'h8000_0000_0000_0021, 1, 1'b0);    // restarts from line 0

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
